ps2_rx: RTL and testbench

// - PS/2 keyboard frame receiver. Sits directly downstream of the PS/2 clock glitch filter.
// - Consumes the filtered PS/2 clock and the raw PS/2 data line.
// - Assembles 11-bit device-to-host frames and strips the E0/F0 prefixes.
// - Emits one clean key event per make/break code to the note-mapping logic.

---
 rtl/ps2_rx.sv | 130 +++++++++++++
 tb/tb_ps2_rx.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ps2_rx.sv
// rtl/ps2_rx.sv - PS/2 device-to-host frame receiver with E0/F0 prefix stripping
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_f,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_break,
  output logic       key_ext,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t        state_q, state_d;
  logic          data_meta_q, data_sync_q;
  logic          clk_prev_q;
  logic [2:0]    cnt_q;
  logic [7:0]    sr_q;
  logic          par_q;
  logic [TW-1:0] tcnt_q;
  logic          ext_pend_q, brk_pend_q;
  logic [7:0]    key_code_q;
  logic          key_valid_q, key_break_q, key_ext_q, frame_err_q;

  logic fall;
  logic timeout;
  logic stop_eval, frame_good;
  logic emit_key, emit_err, set_ext, set_brk;

  assign fall    = clk_prev_q & ~ps2_clk_f;
  assign timeout = (state_q != S_IDLE) && !fall && (tcnt_q == TCNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_IDLE;
    end else if (fall) begin
      case (state_q)
        S_IDLE:   if (!data_sync_q) state_d = S_DATA;
        S_DATA:   if (cnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Frame verdict is taken on the stop-bit fall; all outputs register it one cycle later.
  always_comb begin
    stop_eval  = (state_q == S_STOP) && fall;
    frame_good = data_sync_q && (^{sr_q, par_q});
    emit_key   = stop_eval && frame_good && (sr_q != 8'hE0) && (sr_q != 8'hF0);
    set_ext    = stop_eval && frame_good && (sr_q == 8'hE0);
    set_brk    = stop_eval && frame_good && (sr_q == 8'hF0);
    emit_err   = (stop_eval && !frame_good) || timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_meta_q <= 1'b0;
      data_sync_q <= 1'b0;
      clk_prev_q  <= 1'b0;
      cnt_q       <= '0;
      sr_q        <= '0;
      par_q       <= 1'b0;
      tcnt_q      <= '0;
      ext_pend_q  <= 1'b0;
      brk_pend_q  <= 1'b0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_break_q <= 1'b0;
      key_ext_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      data_meta_q <= ps2_data;
      data_sync_q <= data_meta_q;
      clk_prev_q  <= ps2_clk_f;

      if (fall) begin
        case (state_q)
          S_IDLE:   cnt_q <= '0;
          S_DATA: begin
            sr_q  <= {data_sync_q, sr_q[7:1]};
            cnt_q <= cnt_q + 3'd1;
          end
          S_PARITY: par_q <= data_sync_q;
          default:  ;
        endcase
      end

      if (state_q == S_IDLE || fall) tcnt_q <= '0;
      else                           tcnt_q <= tcnt_q + 1'b1;

      if (emit_key || emit_err) begin
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end else begin
        if (set_ext) ext_pend_q <= 1'b1;
        if (set_brk) brk_pend_q <= 1'b1;
      end

      key_valid_q <= emit_key;
      frame_err_q <= emit_err;
      if (emit_key) begin
        key_code_q  <= sr_q;
        key_break_q <= brk_pend_q;
        key_ext_q   <= ext_pend_q;
      end
    end
  end

  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_break = key_break_q;
  assign key_ext   = key_ext_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb/tb_ps2_rx.sv - scoreboard bench for ps2_rx with a frame-level key-event model
module tb_ps2_rx;

  localparam int TMO  = 2000;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk_f = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_valid, key_break, key_ext, frame_err;

  ps2_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ps2_clk_f(ps2_clk_f), .ps2_data(ps2_data),
    .key_code(key_code), .key_valid(key_valid), .key_break(key_break),
    .key_ext(key_ext), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] code;
    bit         brk;
    bit         ext;
    bit         lat;
  } ev_t;

  ev_t q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  last_stop_cyc = 0;

  // Model: pending prefix flags and the last key reported
  bit         m_brk = 0, m_ext = 0;
  logic [7:0] m_code = 8'h00;
  bit         m_kbrk = 0, m_kext = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (key_valid || frame_err)) begin
      chk("exclusive", int'(key_valid && frame_err), 0);
      if (q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("is_error", int'(frame_err), int'(e.err));
        chk("key_code", int'(key_code), int'(e.code));
        chk("key_break", int'(key_break), int'(e.brk));
        chk("key_ext", int'(key_ext), int'(e.ext));
        if (e.lat) chk("latency", cyc, last_stop_cyc + 1);
      end
    end
  end

  function automatic void push(input bit err, input bit lat);
    ev_t e;
    e.err = err; e.code = m_code; e.brk = m_kbrk; e.ext = m_kext; e.lat = lat;
    q.push_back(e);
  endfunction

  function automatic void model_frame(input logic [7:0] code, input bit ok);
    if (!ok) begin
      m_brk = 0; m_ext = 0;
      push(1'b1, 1'b1);
    end else if (code == 8'hE0) begin
      m_ext = 1;
    end else if (code == 8'hF0) begin
      m_brk = 1;
    end else begin
      m_code = code; m_kbrk = m_brk; m_kext = m_ext;
      m_brk = 0; m_ext = 0;
      push(1'b0, 1'b1);
    end
  endfunction

  task automatic drive_bit(input logic b, input bit is_stop);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk_f = 1'b0;
    if (is_stop) last_stop_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk_f = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    logic par;
    par = (~^code) ^ bad_par;
    model_frame(code, !(bad_par || bad_stop));
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(code[i], 1'b0);
    drive_bit(par, 1'b0);
    drive_bit(!bad_stop, 1'b1);
    ps2_data = 1'b1;
  endtask

  task automatic send_partial(input logic [7:0] code, input int ndata);
    drive_bit(1'b0, 1'b0);
    for (int i = 0; i < ndata; i++) drive_bit(code[i], 1'b0);
    ps2_data = 1'b1;
  endtask

  initial begin
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_key_code", int'(key_code), 0);
    chk("reset_key_valid", int'(key_valid), 0);
    chk("reset_flags", int'({key_break, key_ext, frame_err}), 0);

    send_frame(8'h1C, 0, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'h1C, 0, 0);
    send_frame(8'hE0, 0, 0); send_frame(8'hF0, 0, 0); send_frame(8'h75, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'h1C, 1, 0);
    send_frame(8'hF0, 0, 0); send_frame(8'h33, 1, 0); send_frame(8'h1C, 0, 0);
    send_frame(8'h2A, 0, 1);
    send_frame(8'hE0, 0, 0); send_frame(8'hE0, 0, 0); send_frame(8'h6B, 0, 0);

    // Abandoned frame: the clock stops after four data bits
    send_frame(8'hE0, 0, 0);
    send_partial(8'h5A, 4);
    m_brk = 0; m_ext = 0;
    push(1'b1, 1'b0);
    repeat (TMO + 500) @(negedge clk);
    send_frame(8'h1C, 0, 0);

    // Reset mid-frame with a break prefix pending
    send_frame(8'hF0, 0, 0);
    send_partial(8'h29, 5);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    m_brk = 0; m_ext = 0; m_code = 8'h00; m_kbrk = 0; m_kext = 0;
    @(negedge clk);
    rst = 1'b0;
    chk("midreset_key_code", int'(key_code), 0);
    send_frame(8'h29, 0, 0);

    for (int n = 0; n < 30; n++) begin
      int r;
      logic [7:0] c;
      r = $urandom_range(0, 9);
      c = (r == 0) ? 8'hE0 : (r == 1) ? 8'hF0 : 8'($urandom_range(0, 255));
      send_frame(c, $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
      repeat ($urandom_range(0, 3) * HALF) @(negedge clk);
    end

    repeat (50) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
